// File: rtl/and_or_pipe.sv
// -----------------------------------------------------------------------------
// and_or_pipe
//   Per-bit AND-OR / OR-AND combinational logic on WIDTH-bit operands,
//   followed by a DEPTH-stage elastic pipeline. Both sides use a valid/ready
//   handshake, and downstream backpressure is propagated to the input.
//
// Parameters
//   WIDTH  operand/result width in bits (>=1)
//   DEPTH  number of pipeline register stages (>=1), max items in flight
//   CNT_W  transaction counter width (only with AOR_CNT_EN)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset (0 = reset)
//   in_valid   operands/mode valid this cycle
//   in_ready   block accepts this cycle
//   a,b,c,d    operands
//   mode       0: f=(a&b)|(c&d)   1: f=(a|b)&(c|d)
//   out_valid  f holds a valid result
//   out_ready  consumer accepts
//   f          result from the last stage
//   busy       any stage holds an item
//   txn_count  saturating count of output handshakes (AOR_CNT_EN only)
//
// Configuration macro
//   AOR_CNT_EN  when defined, adds the CNT_W parameter, the txn_count port
//               and its counter register.
// -----------------------------------------------------------------------------
module and_or_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
`ifdef AOR_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             busy
`ifdef AOR_CNT_EN
    ,
    output logic [CNT_W-1:0] txn_count
`endif
);

    // Handshake semantics (both ports): a transfer happens on a rising edge
    // where valid && ready are both 1. valid never depends on ready. in_ready
    // depends combinationally on out_ready, so a full pipeline can accept a
    // new item in the same cycle it hands one to the consumer.

    logic [WIDTH-1:0] result;
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] r_q [DEPTH];
    logic [WIDTH-1:0] r_d [DEPTH];

    // Mode is sampled together with the operands, so the stored result is
    // immune to later mode changes.
    always_comb begin
        if (mode) begin
            result = (a | b) & (c | d);
        end else begin
            result = (a & b) | (c & d);
        end
    end

    // Stage i can take a new item when it, or any stage downstream of it,
    // is empty, or when the consumer is taking the last item. Built with a
    // running accumulator so no bit of rdy is read back.
    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            rdy[i] = acc;
        end
    end

    // Each ready stage pulls from its upstream neighbour; a ready stage whose
    // upstream is empty becomes empty (bubble collapses). Data is only
    // overwritten when a real item moves in.
    always_comb begin
        v_d = v_q;
        r_d = r_q;
        if (rdy[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                r_d[0] = result;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    r_d[i] = r_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            r_q <= r_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[DEPTH-1];
    assign f         = r_q[DEPTH-1];
    assign busy      = |v_q;

`ifdef AOR_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_and_or_pipe.sv
// -----------------------------------------------------------------------------
// tb_and_or_pipe
//   Directed and random stimulus for and_or_pipe (WIDTH=4, DEPTH=2).
//   A negedge monitor pushes the reference result of every accepted input
//   into exp_q and pops/compares on every output handshake. The main initial
//   block drives inputs 1 time unit after each rising edge.
//   With AOR_CNT_EN defined the saturating counter (CNT_W=2) is also tested.
// -----------------------------------------------------------------------------
module tb_and_or_pipe;

    localparam int W     = 4;
    localparam int DEPTH = 2;
`ifdef AOR_CNT_EN
    localparam int CNT_W = 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic [W-1:0] d = '0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] f;
    logic         busy;
`ifdef AOR_CNT_EN
    logic [CNT_W-1:0] txn_count;
`endif

    and_or_pipe #(
        .WIDTH(W),
        .DEPTH(DEPTH)
`ifdef AOR_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .f        (f),
        .busy     (busy)
`ifdef AOR_CNT_EN
        ,
        .txn_count(txn_count)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int acc_n    = 0;
    int out_n    = 0;

    function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [W-1:0] mc, input logic [W-1:0] md,
                                           input logic mm);
        if (mm) return (ma | mb) & (mc | md);
        return (ma & mb) | (mc & md);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: outputs and inputs are all stable at the falling edge; a
    // handshake seen here completes at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_model", in_ready, (exp_q.size() < DEPTH) || out_ready);
            check("busy_model", busy, exp_q.size() != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    check("sb_f", f, exp_q.pop_front());
                end
                out_n++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c, d, mode));
                acc_n++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input logic [W-1:0] id, input logic m);
        in_valid = v;
        a = ia;
        b = ib;
        c = ic;
        d = id;
        mode = m;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
              W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_f", f, 4'h0);
        check("rst_busy", busy, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // 1: mode 0 single item, DEPTH latency, one-cycle output
        out_ready = 1'b1;
        drive(1'b1, 4'b1100, 4'b1010, 4'b0011, 4'b0001, 1'b0);
        #1;
        check("t1_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t1_not_yet", out_valid, 1'b0);
        tick();
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_f", f, 4'b1001);
        tick();
        check("t1_one_cycle", out_valid, 1'b0);

        // 2: mode 1, then flip mode while in flight
        drive(1'b1, 4'b1100, 4'b1010, 4'b0011, 4'b0001, 1'b1);
        tick();
        drive(1'b0, 4'b1100, 4'b1010, 4'b0011, 4'b0001, 1'b0);
        tick();
        check("t2_out_valid", out_valid, 1'b1);
        check("t2_f", f, 4'b0010);
        tick();
        check("t2_done", out_valid, 1'b0);

        // 3: backpressure, fill, stall, release in order
        out_ready = 1'b0;
        drive(1'b1, 4'h3, 4'hF, 4'h0, 4'h0, 1'b0);
        tick();
        drive(1'b1, 4'h5, 4'hF, 4'h0, 4'h0, 1'b0);
        tick();
        drive(1'b1, 4'h9, 4'hF, 4'h0, 4'h0, 1'b0);
        #1;
        check("t3_full_in_ready", in_ready, 1'b0);
        check("t3_f_x0", f, 4'h3);
        tick();
        check("t3_hold_in_ready", in_ready, 1'b0);
        check("t3_hold_valid", out_valid, 1'b1);
        check("t3_hold_f", f, 4'h3);
        out_ready = 1'b1;
        #1;
        check("t3_pass_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t3_x1_valid", out_valid, 1'b1);
        check("t3_x1", f, 4'h5);
        tick();
        check("t3_x2_valid", out_valid, 1'b1);
        check("t3_x2", f, 4'h9);
        tick();
        check("t3_empty", out_valid, 1'b0);

        // 4: asynchronous reset with two items in flight
        out_ready = 1'b0;
        drive(1'b1, 4'h7, 4'hF, 4'h0, 4'h0, 1'b0);
        tick();
        drive(1'b1, 4'hA, 4'hF, 4'h0, 4'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t4_busy_before", busy, 1'b1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        acc_n = 0;
        out_n = 0;
        #1;
        check("t4_rst_valid", out_valid, 1'b0);
        check("t4_rst_f", f, 4'h0);
        check("t4_rst_busy", busy, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 4'hC, 4'hF, 4'h0, 4'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t4_lat_not_yet", out_valid, 1'b0);
        tick();
        check("t4_lat_valid", out_valid, 1'b1);
        check("t4_lat_f", f, 4'hC);
        tick();

        // 5a: full-rate stream, 8 items on 8 consecutive cycles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b1);
            #1;
            check("t5_in_ready", in_ready, 1'b1);
            tick();
            if (i >= 1) check("t5_stream_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        check("t5_last_valid", out_valid, 1'b1);
        drain();

        // 5b: random in_valid / out_ready
        for (int i = 0; i < 60; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        check("t5_in_out_count", out_n, acc_n);

`ifdef AOR_CNT_EN
        // 6: saturating transaction counter
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_count", txn_count, 2'd0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drain();
        check("t6_count2", txn_count, 2'd2);
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drain();
        check("t6_saturated", txn_count, 2'd3);
        rst = 1'b0;
        #1;
        check("t6_cleared", txn_count, 2'd0);
        tick();
        rst = 1'b1;
`endif

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
